// File: rtl/jesd_stream_gearbox.sv
// jesd_stream_gearbox
// Buffers wide sample words and serialises each one into R = DIN_W/DOUT_W
// narrower beats, LSB beat first, under ready/valid backpressure.
// Optional feature macro: GEARBOX_DROP_CNT_EN builds the dropped-word counter.
//
// State table
//   RUN       | normal capture; words written while the buffer has room
//   WAIT_SYNC | flushed by arm; discard words until one carries din_sync
//
// Ports
//   user_clk, user_areset_n      clock, async active-low reset
//   din, din_vld, din_sync       input word, qualifier, frame-start marker
//   dout, dout_vld, dout_rdy     output beat handshake
//   dout_sync                    high on beat 0 of a sync-marked word
//   arm / armed                  flush-and-wait request / WAIT_SYNC indicator
//   overflow, overflow_clr       sticky drop flag and its clear
//   fill                         words held in the buffer (serialiser excluded)
//   drop_cnt                     saturating dropped-word count (0 when not built)
module jesd_stream_gearbox #(
  parameter int DIN_W  = 512,
  parameter int DOUT_W = 128,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              user_clk,
  input  logic              user_areset_n,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_vld,
  input  logic              din_sync,
  output logic [DOUT_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              dout_sync,
  input  logic              arm,
  output logic              armed,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [AW:0]       fill,
  output logic [15:0]       drop_cnt
);

  localparam int R  = DIN_W / DOUT_W;
  localparam int BW = (R > 1) ? $clog2(R) : 1;
  localparam int MW = DIN_W + 1;

  typedef enum logic {RUN, WAIT_SYNC} state_e;

  state_e            state_q, state_d;
  logic [MW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       fill_q, fill_d;
  logic [DIN_W-1:0]  ser_word_q, ser_word_d, ser_shift;
  logic [BW-1:0]     beat_q, beat_d;
  logic              vld_q, vld_d, sync_q, sync_d;
  logic              ovf_q, ovf_d;
  logic              wr_en, pop, drop, xfer, last_beat, full;
  logic [MW-1:0]     rd_data;

  assign full      = (fill_q == (AW+1)'(DEPTH));
  assign xfer      = vld_q & dout_rdy;
  assign last_beat = (beat_q == BW'(R - 1));
  assign rd_data   = mem_q[rd_ptr_q];

  // Next beat sits in the LSBs after a right shift; with R == 1 there is
  // never a non-final beat, so the word is simply held.
  generate
    if (R > 1) begin : g_shift
      assign ser_shift = {{DOUT_W{1'b0}}, ser_word_q[DIN_W-1:DOUT_W]};
    end else begin : g_noshift
      assign ser_shift = ser_word_q;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    drop       = 1'b0;
    pop        = 1'b0;
    ser_word_d = ser_word_q;
    beat_d     = beat_q;
    vld_d      = vld_q;
    sync_d     = sync_q;
    ovf_d      = ovf_q;

    if (arm) begin
      state_d = WAIT_SYNC;
      vld_d   = 1'b0;
      sync_d  = 1'b0;
      beat_d  = '0;
    end else begin
      if (state_q == WAIT_SYNC) begin
        if (din_vld && din_sync) begin
          wr_en   = 1'b1;
          state_d = RUN;
        end
      end else if (din_vld) begin
        wr_en = !full;
        drop  = full;
      end

      if (!vld_q || (xfer && last_beat)) begin
        pop        = (fill_q != '0);
        vld_d      = pop;
        sync_d     = pop & rd_data[MW-1];
        beat_d     = '0;
        if (pop) ser_word_d = rd_data[DIN_W-1:0];
      end else if (xfer) begin
        ser_word_d = ser_shift;
        beat_d     = beat_q + BW'(1);
        sync_d     = 1'b0;
      end
    end

    // A drop in the same cycle as the clear wins, so the event is not lost.
    if (drop)              ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;

    wr_ptr_d = arm ? '0 : wr_ptr_q + AW'(wr_en);
    rd_ptr_d = arm ? '0 : rd_ptr_q + AW'(pop);
    fill_d   = arm ? '0 : fill_q + (AW+1)'(wr_en) - (AW+1)'(pop);
  end

  always_ff @(posedge user_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {din_sync, din};
  end

  always_ff @(posedge user_clk or negedge user_areset_n) begin
    if (!user_areset_n) begin
      state_q    <= RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      ser_word_q <= '0;
      beat_q     <= '0;
      vld_q      <= 1'b0;
      sync_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      ser_word_q <= ser_word_d;
      beat_q     <= beat_d;
      vld_q      <= vld_d;
      sync_q     <= sync_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef GEARBOX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (overflow_clr)                     drop_cnt_d = {15'd0, drop};
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge user_clk or negedge user_areset_n) begin
    if (!user_areset_n) drop_cnt_q <= '0;
    else                drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'd0;
`endif

  assign dout      = ser_word_q[DOUT_W-1:0];
  assign dout_vld  = vld_q;
  assign dout_sync = sync_q;
  assign armed     = (state_q == WAIT_SYNC);
  assign overflow  = ovf_q;
  assign fill      = fill_q;

endmodule

// File: tb/tb_jesd_stream_gearbox.sv
module tb_jesd_stream_gearbox;
  localparam int DIN_W  = 512;
  localparam int DOUT_W = 128;
  localparam int DEPTH  = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int R      = DIN_W / DOUT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DIN_W-1:0]  din;
  logic              din_vld, din_sync;
  logic [DOUT_W-1:0] dout;
  logic              dout_vld, dout_rdy, dout_sync;
  logic              arm, armed, overflow, overflow_clr;
  logic [AW:0]       fill;
  logic [15:0]       drop_cnt;

  jesd_stream_gearbox #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .DEPTH(DEPTH)) dut (
    .user_clk(clk), .user_areset_n(rst_n), .din(din), .din_vld(din_vld),
    .din_sync(din_sync), .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_sync(dout_sync), .arm(arm), .armed(armed), .overflow(overflow),
    .overflow_clr(overflow_clr), .fill(fill), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats_out = 0;
  bit rand_rdy = 0;
  bit chk_stable = 0;
  logic [DOUT_W:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a beat is taken on the coming edge when vld & rdy.
  logic              hold_prev = 1'b0;
  logic [DOUT_W-1:0] dout_prev;
  logic              sync_prev;
  logic [DOUT_W:0]   e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_stable && hold_prev) begin
        checks++;
        if (!dout_vld || dout !== dout_prev || dout_sync !== sync_prev) begin
          errors++;
          $display("FAIL stable: vld %0b sync %0b dout %0h expected held sync %0b dout %0h",
                   dout_vld, dout_sync, dout, sync_prev, dout_prev);
        end
      end
      hold_prev = dout_vld & !dout_rdy;
      dout_prev = dout;
      sync_prev = dout_sync;
      if (dout_vld && dout_rdy) begin
        beats_out++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat: unexpected beat sync %0b dout %0h, expected none", dout_sync, dout);
        end else begin
          e = exp_q.pop_front();
          if ({dout_sync, dout} !== e) begin
            errors++;
            $display("FAIL beat: got sync %0b dout %0h expected sync %0b dout %0h",
                     dout_sync, dout, e[DOUT_W], e[DOUT_W-1:0]);
          end
        end
      end
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) dout_rdy = 1'($urandom_range(0, 1));
  endtask

  // Reference: an accepted word yields R beats, LSB slice first, sync on beat 0 only.
  task automatic expect_word(input logic [DIN_W-1:0] w, input logic s);
    for (int k = 0; k < R; k++)
      exp_q.push_back({(k == 0) ? s : 1'b0, w[k*DOUT_W +: DOUT_W]});
  endtask

  task automatic send(input logic [DIN_W-1:0] w, input logic s, input bit acc);
    din = w; din_sync = s; din_vld = 1'b1;
    if (acc) expect_word(w, s);
    tick();
    din_vld = 1'b0; din_sync = 1'b0;
  endtask

  function automatic logic [DIN_W-1:0] rand_word();
    logic [DIN_W-1:0] w;
    for (int i = 0; i < DIN_W/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !dout_vld) break;
      tick();
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    chk("drain_vld", 32'(dout_vld), 0);
  endtask

  logic [DIN_W-1:0] w;
  int base;

  initial begin
    rst_n = 1'b0; din = '0; din_vld = 0; din_sync = 0; dout_rdy = 0;
    arm = 0; overflow_clr = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_dout", 32'(dout == '0), 1);
    chk("rst_vld", 32'(dout_vld), 0);
    chk("rst_sync", 32'(dout_sync), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_drop", 32'(drop_cnt), 0);

    // Byte-index pattern, latency 2, LSB-first beats, sync on beat 0.
    dout_rdy = 1'b1;
    for (int i = 0; i < DIN_W/8; i++) w[i*8 +: 8] = 8'(i);
    send(w, 1'b1, 1'b1);
    chk("lat_fill", 32'(fill), 1);
    chk("lat_vld_n", 32'(dout_vld), 0);
    tick();
    chk("lat_vld_n1", 32'(dout_vld), 1);
    chk("lat_sync0", 32'(dout_sync), 1);
    drain(20);

    // Overflow: serialiser + DEPTH words held, 3 dropped.
    dout_rdy = 1'b0;
    for (int i = 0; i < 20; i++) send(rand_word(), 1'(i % 3 == 0), i < DEPTH + 1);
    chk("ovf_fill", 32'(fill), DEPTH);
    chk("ovf_flag", 32'(overflow), 1);
`ifdef GEARBOX_DROP_CNT_EN
    chk("ovf_drop_cnt", 32'(drop_cnt), 3);
`else
    chk("ovf_drop_cnt", 32'(drop_cnt), 0);
`endif
    overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 0);
    chk("ovf_clr_cnt", 32'(drop_cnt), 0);
    base = beats_out;
    dout_rdy = 1'b1;
    drain(17 * R + 20);
    chk("ovf_beats", 32'(beats_out - base), 17 * R);

    // Random backpressure, one word every 8 cycles.
    rand_rdy = 1; chk_stable = 1;
    for (int i = 0; i < 100; i++) begin
      send(rand_word(), 1'($urandom_range(0, 1)), 1'b1);
      repeat (7) tick();
    end
    drain(400);
    rand_rdy = 0; chk_stable = 0;
    chk("rand_ovf", 32'(overflow), 0);

    // arm with beat 2 pending.
    dout_rdy = 1'b0;
    send(rand_word(), 1'b1, 1'b1);
    tick();
    dout_rdy = 1'b1; tick(); tick(); dout_rdy = 1'b0;
    arm = 1'b1; exp_q.delete(); tick(); arm = 1'b0;
    chk("arm_vld", 32'(dout_vld), 0);
    chk("arm_armed", 32'(armed), 1);
    for (int i = 0; i < 3; i++) send(rand_word(), 1'b0, 1'b0);
    chk("arm_nosync_fill", 32'(fill), 0);
    chk("arm_nosync_armed", 32'(armed), 1);
    chk("arm_nosync_ovf", 32'(overflow), 0);
    send(rand_word(), 1'b1, 1'b1);
    chk("arm_sync_armed", 32'(armed), 0);
    chk("arm_sync_fill", 32'(fill), 1);
    dout_rdy = 1'b1;
    drain(20);

    // arm coincident with a sync word: word discarded, stays armed.
    din = rand_word(); din_vld = 1'b1; din_sync = 1'b1; arm = 1'b1;
    tick();
    arm = 1'b0; din_vld = 1'b0; din_sync = 1'b0;
    chk("armsync_armed", 32'(armed), 1);
    chk("armsync_fill", 32'(fill), 0);
    tick();
    chk("armsync_hold", 32'(armed), 1);
    chk("armsync_vld", 32'(dout_vld), 0);
    send(rand_word(), 1'b1, 1'b1);
    chk("armsync_run", 32'(armed), 0);
    drain(20);

    // Asynchronous reset mid-transfer.
    send(rand_word(), 1'b0, 1'b1);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_vld", 32'(dout_vld), 0);
    chk("arst_dout", 32'(dout == '0), 1);
    chk("arst_sync", 32'(dout_sync), 0);
    chk("arst_fill", 32'(fill), 0);
    tick();
    rst_n = 1'b1;
    tick();
    send(rand_word(), 1'b1, 1'b1);
    chk("arst_lat_n", 32'(dout_vld), 0);
    tick();
    chk("arst_lat_n1", 32'(dout_vld), 1);
    drain(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
